// File: rtl/mux4_scan_ctrl.sv
// Channel scanner driving the select lines of a 4:1 conditional-data mux.
// Visits the enabled channels in ascending order, settles each one, samples zout and assembles a frame.
module mux4_scan_ctrl #(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic [3:0] channel_mask,
    input  logic       mux_in,
    output logic       sela,
    output logic       selc,
    output logic       busy,
    output logic       sample_valid,
    output logic [1:0] sample_ch,
    output logic       sample_bit,
    output logic [3:0] frame,
    output logic       frame_valid
);

    typedef enum logic {ST_IDLE, ST_SETTLE} state_t;

    localparam logic [3:0] LOAD = 4'(SETTLE - 1);

    state_t     state, state_d;
    logic [3:0] mask_q, mask_d;
    logic [1:0] ch, ch_d;
    logic [3:0] cnt, cnt_d;
    logic [3:0] shadow, shadow_d;
    logic [3:0] frame_d;
    logic       sv_d, fv_d;
    logic [1:0] sch_d;
    logic       sbit_d;
    logic [3:0] captured;
    logic [2:0] first, nxt;

    // Lowest enabled channel at index >= from; bit 2 flags that one exists.
    function automatic logic [2:0] find_from(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

    assign first = find_from(channel_mask, 3'd0);
    assign nxt   = find_from(mask_q, {1'b0, ch} + 3'd1);

    assign sela = ch[1];
    assign selc = ch[0];
    assign busy = (state != ST_IDLE);

    always_comb begin
        state_d  = state;
        mask_d   = mask_q;
        ch_d     = ch;
        cnt_d    = cnt;
        shadow_d = shadow;
        frame_d  = frame;
        sv_d     = 1'b0;
        fv_d     = 1'b0;
        sch_d    = sample_ch;
        sbit_d   = sample_bit;
        captured = shadow;
        captured[ch] = mux_in;
        case (state)
            ST_IDLE: begin
                if (start && (channel_mask != 4'd0)) begin
                    state_d  = ST_SETTLE;
                    mask_d   = channel_mask;
                    ch_d     = first[1:0];
                    cnt_d    = LOAD;
                    shadow_d = 4'd0;
                end
            end
            ST_SETTLE: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    sv_d     = 1'b1;
                    sch_d    = ch;
                    sbit_d   = mux_in;
                    shadow_d = captured;
                    if (nxt[2]) begin
                        ch_d  = nxt[1:0];
                        cnt_d = LOAD;
                    end else begin
                        // Frame end: publish, then either restart with a fresh mask or stop.
                        frame_d = captured;
                        fv_d    = 1'b1;
                        mask_d  = channel_mask;
                        if (continuous && (channel_mask != 4'd0)) begin
                            ch_d     = first[1:0];
                            cnt_d    = LOAD;
                            shadow_d = 4'd0;
                        end else begin
                            state_d = ST_IDLE;
                            ch_d    = 2'd0;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            mask_q       <= 4'd0;
            ch           <= 2'd0;
            cnt          <= 4'd0;
            shadow       <= 4'd0;
            frame        <= 4'd0;
            sample_valid <= 1'b0;
            frame_valid  <= 1'b0;
            sample_ch    <= 2'd0;
            sample_bit   <= 1'b0;
        end else begin
            state        <= state_d;
            mask_q       <= mask_d;
            ch           <= ch_d;
            cnt          <= cnt_d;
            shadow       <= shadow_d;
            frame        <= frame_d;
            sample_valid <= sv_d;
            frame_valid  <= fv_d;
            sample_ch    <= sch_d;
            sample_bit   <= sbit_d;
        end
    end

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Scoreboard bench for mux4_scan_ctrl: a SETTLE=2 instance for most scenarios, a SETTLE=1 instance for the corner.
module tb_mux4_scan_ctrl;

    typedef struct {int cyc; logic [1:0] ch; logic b;} samp_t;
    typedef struct {int cyc; logic [3:0] f;} frm_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, start1 = 1'b0;
    logic       continuous = 1'b0;
    logic [3:0] channel_mask = 4'd0;
    logic [3:0] d = 4'd0;
    int         cyc = 0;
    int         checks = 0, errors = 0;

    logic       sela, selc, busy, sample_valid, sample_bit, frame_valid, mux_in;
    logic [1:0] sample_ch;
    logic [3:0] frame;
    logic       sela1, selc1, busy1, sample_valid1, sample_bit1, frame_valid1, mux_in1;
    logic [1:0] sample_ch1;
    logic [3:0] frame1;

    samp_t sq0[$], sq1[$];
    frm_t  fq0[$], fq1[$];
    logic  watch_odd = 1'b0;
    logic  odd_seen = 1'b0;

    assign mux_in  = d[{sela, selc}];
    assign mux_in1 = d[{sela1, selc1}];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux4_scan_ctrl #(.SETTLE(2)) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous),
        .channel_mask(channel_mask), .mux_in(mux_in), .sela(sela), .selc(selc),
        .busy(busy), .sample_valid(sample_valid), .sample_ch(sample_ch),
        .sample_bit(sample_bit), .frame(frame), .frame_valid(frame_valid)
    );

    mux4_scan_ctrl #(.SETTLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .continuous(1'b0),
        .channel_mask(channel_mask), .mux_in(mux_in1), .sela(sela1), .selc(selc1),
        .busy(busy1), .sample_valid(sample_valid1), .sample_ch(sample_ch1),
        .sample_bit(sample_bit1), .frame(frame1), .frame_valid(frame_valid1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected pulse at cycle %0d, expected none", name, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_until(input int c);
        while (cyc < c) tick();
    endtask

    // Expected samples and frame for one scan accepted at edge a; data/mask are hand-chosen vectors.
    task automatic expect_frame(input int inst, input int a, input int settle,
                                input logic [3:0] mask, input logic [3:0] data);
        int n;
        samp_t s;
        frm_t f;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                n++;
                s.cyc = a + settle * n; s.ch = 2'(i); s.b = data[i];
                if (inst == 0) sq0.push_back(s); else sq1.push_back(s);
            end
        end
        f.cyc = a + settle * n;
        f.f   = mask & data;
        if (inst == 0) fq0.push_back(f); else fq1.push_back(f);
    endtask

    task automatic drain(input int limit);
        int i;
        i = 0;
        while ((sq0.size() + fq0.size() + sq1.size() + fq1.size()) != 0 && i < limit) begin
            tick();
            i++;
        end
        chk("drain pending", 32'(sq0.size() + fq0.size() + sq1.size() + fq1.size()), 32'd0);
    endtask

    task automatic issue_start(output int a);
        start = 1'b1;
        tick();
        start = 1'b0;
        a = cyc;
    endtask

    initial begin
        int   a;
        samp_t s;
        frm_t  f;

        fork
            forever begin
                @(negedge clk);
                if (watch_odd && selc) odd_seen = 1'b1;
                if (sample_valid) begin
                    if (sq0.size() == 0) unexpected("sample_valid");
                    else begin
                        s = sq0.pop_front();
                        chk("sample cycle", 32'(cyc), 32'(s.cyc));
                        chk("sample_ch", 32'(sample_ch), 32'(s.ch));
                        chk("sample_bit", 32'(sample_bit), 32'(s.b));
                    end
                end
                if (frame_valid) begin
                    if (fq0.size() == 0) unexpected("frame_valid");
                    else begin
                        f = fq0.pop_front();
                        chk("frame cycle", 32'(cyc), 32'(f.cyc));
                        chk("frame", 32'(frame), 32'(f.f));
                    end
                end
                if (sample_valid1) begin
                    if (sq1.size() == 0) unexpected("sample_valid s1");
                    else begin
                        s = sq1.pop_front();
                        chk("s1 sample cycle", 32'(cyc), 32'(s.cyc));
                        chk("s1 sample_ch", 32'(sample_ch1), 32'(s.ch));
                        chk("s1 sample_bit", 32'(sample_bit1), 32'(s.b));
                    end
                end
                if (frame_valid1) begin
                    if (fq1.size() == 0) unexpected("frame_valid s1");
                    else begin
                        f = fq1.pop_front();
                        chk("s1 frame cycle", 32'(cyc), 32'(f.cyc));
                        chk("s1 frame", 32'(frame1), 32'(f.f));
                    end
                end
            end
        join_none

        // Reset state
        repeat (3) tick();
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset sel", 32'({sela, selc}), 32'd0);
        chk("reset frame", 32'(frame), 32'd0);
        rst = 1'b0;
        tick();

        // Full scan: d0..d3 = 1,0,1,1 -> frame 1101, plus a stray start while busy
        d = 4'b1101;
        channel_mask = 4'b1111;
        issue_start(a);
        chk("busy after start", 32'(busy), 32'd1);
        chk("sel ch0", 32'({sela, selc}), 32'd0);
        expect_frame(0, a, 2, 4'b1111, 4'b1101);
        tick_until(a + 3);
        chk("sel ch1", 32'({sela, selc}), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        drain(40);
        chk("busy low after frame", 32'(busy), 32'd0);
        chk("sel idle", 32'({sela, selc}), 32'd0);
        repeat (6) tick();

        // Masked scan 0101 with all-ones data: only ch0, ch2 visited
        d = 4'b1111;
        channel_mask = 4'b0101;
        odd_seen = 1'b0;
        watch_odd = 1'b1;
        issue_start(a);
        expect_frame(0, a, 2, 4'b0101, 4'b1111);
        drain(40);
        watch_odd = 1'b0;
        chk("masked odd select seen", 32'(odd_seen), 32'd0);

        // Start with zero mask is ignored
        channel_mask = 4'b0000;
        issue_start(a);
        chk("zero-mask busy", 32'(busy), 32'd0);
        repeat (5) tick();
        chk("zero-mask still idle", 32'(busy), 32'd0);

        // Continuous, mask 1000: frames 1000, 0000, then 1000 after continuous drops
        d = 4'b1000;
        channel_mask = 4'b1000;
        continuous = 1'b1;
        issue_start(a);
        expect_frame(0, a, 2, 4'b1000, 4'b1000);
        tick_until(a + 2);
        chk("continuous busy", 32'(busy), 32'd1);
        d = 4'b0000;
        expect_frame(0, a + 2, 2, 4'b1000, 4'b0000);
        tick_until(a + 4);
        continuous = 1'b0;
        d = 4'b1000;
        expect_frame(0, a + 4, 2, 4'b1000, 4'b1000);
        drain(40);
        chk("continuous stop busy", 32'(busy), 32'd0);
        repeat (6) tick();

        // Reset during the ch1 settle aborts the scan; a fresh start behaves normally
        d = 4'b1101;
        channel_mask = 4'b1111;
        issue_start(a);
        expect_frame(0, a, 2, 4'b1111, 4'b1101);
        tick_until(a + 3);
        chk("pre-reset sel ch1", 32'({sela, selc}), 32'd1);
        sq0.delete();
        fq0.delete();
        rst = 1'b1;
        tick();
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst sel", 32'({sela, selc}), 32'd0);
        chk("rst sample_valid", 32'(sample_valid), 32'd0);
        chk("rst sample_ch/bit", 32'({sample_ch, sample_bit}), 32'd0);
        chk("rst frame/frame_valid", 32'({frame, frame_valid}), 32'd0);
        rst = 1'b0;
        repeat (8) tick();
        issue_start(a);
        expect_frame(0, a, 2, 4'b1111, 4'b1101);
        drain(40);
        chk("post-reset busy", 32'(busy), 32'd0);

        // SETTLE=1: four back-to-back samples, frame four edges after acceptance
        d = 4'b0110;
        channel_mask = 4'b1111;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        a = cyc;
        expect_frame(1, a, 1, 4'b1111, 4'b0110);
        drain(20);
        chk("s1 busy after frame", 32'(busy1), 32'd0);
        repeat (4) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
